// File: rtl/output_mem_drain.sv
// Read-side sequencer: walks a range of output-memory rows via the scan-out port and streams
// each row as OUT_W-bit beats over valid/ready. Optional running beat sum: OUT_DRAIN_CHECKSUM_EN.
module output_mem_drain #(
    parameter int ROW_W  = 512,
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_rows,
    output logic [1:0]        scan_mode,
    output logic [ADDR_W-1:0] scan_addr,
    input  logic [ROW_W-1:0]  scan_out,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum
);

    localparam int BEATS  = ROW_W / OUT_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SCAN = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPTURE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [ADDR_W-1:0]   r_rows_left;
    logic [ROW_W-1:0]    r_row_buf;
    logic [BEAT_W-1:0]   r_beat;

    logic                w_start_ok;
    logic                w_handshake;
    logic                w_last_beat;
    logic                w_last_row;
    logic [OUT_W-1:0]    w_words [BEATS];

    assign w_start_ok  = (r_state == S_IDLE) && start;
    assign w_handshake = (r_state == S_STREAM) && out_ready;
    assign w_last_beat = (r_beat == BEAT_LAST);
    assign w_last_row  = (r_rows_left == ADDR_W'(1));
    assign scan_addr   = r_cur_addr;

    always_comb begin
        for (int i = 0; i < BEATS; i++) begin
            w_words[i] = r_row_buf[i*OUT_W +: OUT_W];
        end
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs decode r_state only; out_ready feeds just the next-state logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        scan_mode    = MODE_LOAD;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = (num_rows == '0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                scan_mode    = MODE_SCAN;
                w_next_state = S_CAPTURE;
            end
            S_CAPTURE: begin
                scan_mode    = MODE_SCAN;
                w_next_state = S_STREAM;
            end
            S_STREAM: begin
                scan_mode = MODE_SCAN;
                out_valid = 1'b1;
                out_data  = w_words[r_beat];
                out_last  = w_last_beat && w_last_row;
                if (out_ready && w_last_beat) begin
                    w_next_state = w_last_row ? S_DONE : S_ADDR;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: the wide row buffer is reset too, so an aborted drain leaves no
    // stale row data visible on out_data after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_addr  <= '0;
            r_rows_left <= '0;
            r_row_buf   <= '0;
            r_beat      <= '0;
        end else begin
            if (w_start_ok) begin
                r_cur_addr  <= base_addr;
                r_rows_left <= num_rows;
            end
            if (r_state == S_CAPTURE) begin
                r_row_buf <= scan_out;
                r_beat    <= '0;
            end
            if (w_handshake) begin
                if (w_last_beat) begin
                    r_beat      <= '0;
                    r_rows_left <= r_rows_left - ADDR_W'(1);
                    if (!w_last_row) begin
                        r_cur_addr <= r_cur_addr + ADDR_W'(1);
                    end
                end else begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end
        end
    end

`ifdef OUT_DRAIN_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_handshake) begin
            r_checksum <= r_checksum + 32'(out_data);
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: doc/output_mem_drain.md
# output_mem_drain

Read-side sequencer for the output memory: walks a contiguous range of 512-bit output rows through the memory's scan-out port and streams each row to the host or testbench as narrow beats over a valid/ready handshake. It sits between `output_mem_top` and the chip's result-readout path. It is the reader counterpart to the controllers that write convolution results into the output memory.

## Interface
Parameters:
- `ROW_W`, 512, row width; must equal the output memory data width.
- `OUT_W`, 32, beat width; must divide `ROW_W`. Beats per row `BEATS = ROW_W/OUT_W` (16 by default).
- `ADDR_W`, 8, row address width.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first row address; latched on accepted `start`.
- `num_rows`  in  ADDR_W  rows to drain; latched on accepted `start`; 0 means no rows.
- `scan_mode`  out  2  drives the memory mode: 2'b01 (LOAD, normal operation) when not draining, 2'b11 (SCAN_OUT) while draining.
- `scan_addr`  out  ADDR_W  row address presented to the memory.
- `scan_out`  in  ROW_W  row data returned by the memory.
- `out_data`  out  OUT_W  current beat.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  consumer ready.
- `out_last`  out  1  final beat of the final row.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `checksum`  out  32  running beat sum (see Configuration).

## Operation
- FSM states: IDLE, ADDR, CAPTURE, STREAM, DONE.
- IDLE → on `start`: latch `base_addr` into `cur_addr` and `num_rows` into `rows_left`, and clear `checksum`. Go to DONE if `num_rows`==0, otherwise go to ADDR.
- ADDR: drive `scan_addr=cur_addr` and `scan_mode=2'b11`. Next state is CAPTURE.
- CAPTURE: hold `scan_addr`. Register `scan_out` into `row_buf`, set `beat=0`, then go to STREAM.
- STREAM:
  - `out_valid=1` and `out_data=row_buf[beat*OUT_W +: OUT_W]`, LSB slice first.
  - A handshake (`out_valid && out_ready`) advances `beat`.
  - On the handshake with `beat==BEATS-1`, decrement `rows_left`. If rows remain, set `cur_addr=cur_addr+1` (modulo 2^ADDR_W; 255 wraps to 0) and go to ADDR. Otherwise go to DONE.
- `out_last` = STREAM && `beat==BEATS-1` && `rows_left==1`.
- DONE: assert `done` for one cycle, then go to IDLE.
- `scan_mode=2'b11` in ADDR, CAPTURE and STREAM. It is 2'b01 in IDLE and DONE.
- `start` is ignored while `busy`. A `start` in the same cycle as DONE is also ignored.
- While `out_valid && !out_ready`, `out_data`, `out_last` and `beat` hold stable. `row_buf` never changes during STREAM.
- Reset mid-operation aborts immediately with no `done` pulse. No partial state survives.

## Timing
- Reset values:
  - state IDLE; `scan_mode`=2'b01; `scan_addr`=0.
  - `out_data`=0, `out_valid`=0, `out_last`=0.
  - `busy`=0, `done`=0, `checksum`=0.
- Read latency: `scan_addr` is stable for two edges (ADDR, CAPTURE), and `scan_out` is sampled at the end of CAPTURE.
- Cycle numbering: `start` is sampled at edge 0, giving ADDR in cycle 1, CAPTURE in cycle 2, and the first `out_valid` in cycle 3.
- With `out_ready` held high, each row costs 2+BEATS = 18 cycles. N rows take 18N cycles, followed by the `done` cycle.
- `done` is asserted in the cycle immediately after the final handshake.
- All outputs are registered or decoded only from state registers. There is no combinational path from `out_ready` to `out_valid`.

## Configuration
- `OUT_DRAIN_CHECKSUM_EN` defined:
  - On every handshake, `checksum <= checksum + out_data` (zero-extended to 32 bits, modulo 2^32).
  - `checksum` is cleared on an accepted `start`.
  - It holds its value from DONE until the next `start`.
- Not defined: `checksum` is tied to 0 and no adder is built.

## Test plan
- Reset/idle: assert `reset` mid-STREAM with row 2 of 4 pending → all outputs return to reset values immediately, no `done` pulse, and `scan_mode`=2'b01.
- Single row:
  - Setup: `base_addr`=5, `num_rows`=1, row 5 = {16 words 0..15}, `out_ready`=1.
  - Expected: beats 0,1,…,15 in cycles 3..18, `out_last` only on beat 15, `done` in cycle 19.
  - With the macro defined, `checksum`=120.
- Backpressure: same setup with `out_ready` toggling 1,0,0,1 → every beat appears exactly once in order, `out_data` stable while stalled, no beat dropped or duplicated.
- Wrap-around: `base_addr`=254, `num_rows`=3 → `scan_addr` sequence 254, 255, 0; 48 beats; `out_last` on beat 48 only.
- Zero rows: `num_rows`=0 → `done` one cycle after `start`, `out_valid` never asserted, `scan_mode` stays 2'b01.
- Ignored start: pulse `start` with `base_addr`=9 during STREAM of a 2-row drain from 0 → rows 0 and 1 are drained, row 9 is never addressed, and exactly one `done` pulse occurs.
